// File: rtl/uart_sample_packetizer_if.sv
// Sample-stream and UART-transmit signals shared by the packetizer and its environment.
// The master side is the packetizer; the slave side is the sample source plus rs232_uart.
interface uart_sample_packetizer_if;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_buffer_full;

    modport master (
        input  sample_in,
        input  sample_valid,
        input  tx_buffer_full,
        output sample_ready,
        output tx_data,
        output tx_write
    );

    modport slave (
        output sample_in,
        output sample_valid,
        output tx_buffer_full,
        input  sample_ready,
        input  tx_data,
        input  tx_write
    );
endinterface

// File: rtl/uart_sample_packetizer.sv
// Frames 16-bit samples into HEADER/LEN/big-endian samples/XOR-checksum byte packets
// for the UART transmitter, spacing writes so a registered FIFO-full flag is never overrun.
module uart_sample_packetizer #(
    parameter int unsigned PKT_SAMPLES = 32,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_enable,
    uart_sample_packetizer_if.master bus,
    output logic                     o_busy,
    output logic [15:0]              o_pkt_count
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LEN,
        LOAD,
        MSB,
        LSB,
        CSUM
    } state_t;

    localparam logic [7:0] LEN_BYTE = 8'(PKT_SAMPLES);

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_hold;
    logic [7:0]  r_count;
    logic [7:0]  r_csum;
    logic [7:0]  r_txData;
    logic        r_txWrite;
    logic        r_holdoff;
    logic [15:0] r_pktCount;

    logic        w_canWrite;
    logic        w_take;
    logic        w_write;
    logic [7:0]  w_byte;

    assign w_canWrite = !bus.tx_buffer_full && !r_holdoff;
    assign w_take     = (r_state == LOAD) && bus.sample_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Every emitting state offers its byte and advances only when the write is allowed.
    always_comb begin
        w_nextState = r_state;
        w_write     = 1'b0;
        w_byte      = r_txData;
        case (r_state)
            IDLE: begin
                if (i_enable && bus.sample_valid) begin
                    w_nextState = HDR;
                end
            end
            HDR: begin
                w_byte = HEADER;
                if (w_canWrite) begin
                    w_write     = 1'b1;
                    w_nextState = LEN;
                end
            end
            LEN: begin
                w_byte = LEN_BYTE;
                if (w_canWrite) begin
                    w_write     = 1'b1;
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                if (w_take) begin
                    w_nextState = MSB;
                end
            end
            MSB: begin
                w_byte = r_hold[15:8];
                if (w_canWrite) begin
                    w_write     = 1'b1;
                    w_nextState = LSB;
                end
            end
            LSB: begin
                w_byte = r_hold[7:0];
                if (w_canWrite) begin
                    w_write     = 1'b1;
                    w_nextState = (r_count == LEN_BYTE) ? CSUM : LOAD;
                end
            end
            CSUM: begin
                w_byte = r_csum;
                if (w_canWrite) begin
                    w_write     = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The holdoff flag blanks the cycle right after each write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold     <= 16'h0000;
            r_count    <= 8'h00;
            r_csum     <= 8'h00;
            r_txData   <= 8'h00;
            r_txWrite  <= 1'b0;
            r_holdoff  <= 1'b0;
            r_pktCount <= 16'h0000;
        end else begin
            r_txWrite <= w_write;
            r_holdoff <= w_write;
            if (w_write) begin
                r_txData <= w_byte;
            end
            if (w_take) begin
                r_hold  <= bus.sample_in;
                r_count <= r_count + 8'd1;
            end
            if (w_write) begin
                case (r_state)
                    HDR:      r_csum <= 8'h00;
                    LEN:      r_csum <= LEN_BYTE;
                    MSB, LSB: r_csum <= r_csum ^ w_byte;
                    CSUM: begin
                        r_count    <= 8'h00;
                        r_pktCount <= r_pktCount + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.tx_data      = r_txData;
    assign bus.tx_write     = r_txWrite;
    assign bus.sample_ready = (r_state == LOAD);
    assign o_busy           = (r_state != IDLE);
    assign o_pkt_count      = r_pktCount;

endmodule

// File: tb/tb_uart_sample_packetizer.sv
// Scoreboard bench for uart_sample_packetizer with two-sample packets: stimulus queues the
// expected byte stream, a monitor checks every UART write and the spacing between writes.
module tb_uart_sample_packetizer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        busy;
    logic [15:0] pktCount;

    uart_sample_packetizer_if bus();

    uart_sample_packetizer #(
        .PKT_SAMPLES(2),
        .HEADER     (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_enable   (enable),
        .bus        (bus),
        .o_busy     (busy),
        .o_pkt_count(pktCount)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cycleCnt = 0;
    int         lastWrite = -100;
    logic [7:0] expQ[$];

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycleCnt);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout expected event at cycle %0d", name, cycleCnt);
    endtask

    // Every UART write must match the next queued byte and trail the previous write by two cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_write === 1'b1) begin
                checkOutput("writeGapOk", 32'(cycleCnt - lastWrite >= 2), 32'd1);
                lastWrite = cycleCnt;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedWrite: got %0h expected no write", bus.tx_data);
                end else begin
                    checkOutput("txByte", 32'(bus.tx_data), 32'(expQ.pop_front()));
                end
            end
        end
    end

    // Called and returns on a falling edge; optionally raises tx_buffer_full just before the handshake.
    task automatic sendSample(input logic [15:0] d, input bit stall);
        bit done = 0;
        bus.sample_in    = d;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            if (bus.sample_ready === 1'b1) begin
                if (stall) bus.tx_buffer_full = 1'b1;
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) timeoutFail("sampleHandshake");
    endtask

    // mode 0 plain, 1 backpressure in MSB, 2 upstream starvation in LOAD, 3 enable dropped mid-packet.
    task automatic applyStimulus(input logic [15:0] s0, input logic [15:0] s1,
                                 input logic [7:0] csum, input int mode);
        int writes;
        int readyCnt;
        bit seen;
        expQ.push_back(8'hA5);
        expQ.push_back(8'h02);
        expQ.push_back(s0[15:8]);
        expQ.push_back(s0[7:0]);
        expQ.push_back(s1[15:8]);
        expQ.push_back(s1[7:0]);
        expQ.push_back(csum);
        sendSample(s0, mode == 1);
        if (mode == 1) begin
            writes = 0;
            for (int i = 0; i < 50; i++) begin
                if (bus.tx_write === 1'b1) writes++;
                @(negedge clk);
            end
            bus.tx_buffer_full = 1'b0;
            checkOutput("stallWrites", 32'(writes), 32'd0);
        end
        if (mode == 2) begin
            bus.sample_valid = 1'b0;
            seen = 0;
            for (int i = 0; i < 300 && !seen; i++) begin
                @(negedge clk);
                if (bus.sample_ready === 1'b1) seen = 1;
            end
            if (!seen) timeoutFail("reachLoad");
            writes = 0;
            readyCnt = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.tx_write === 1'b1) writes++;
                if (bus.sample_ready === 1'b1) readyCnt++;
            end
            checkOutput("starveWrites", 32'(writes), 32'd0);
            checkOutput("starveReady", 32'(readyCnt), 32'd20);
        end
        if (mode == 3) enable = 1'b0;
        sendSample(s1, 1'b0);
        if (mode == 3) begin
            bus.sample_in = 16'h7777;
        end else begin
            bus.sample_valid = 1'b0;
        end
    endtask

    task automatic waitIdle();
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (busy === 1'b0 && expQ.size() == 0) done = 1;
            else @(negedge clk);
        end
        if (!done) timeoutFail("waitIdle");
    endtask

    task automatic countBusy(input int n, input string name);
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) cnt++;
        end
        checkOutput(name, 32'(cnt), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "TxWrite"}, 32'(bus.tx_write), 32'd0);
        checkOutput({tag, "TxData"}, 32'(bus.tx_data), 32'd0);
        checkOutput({tag, "Ready"}, 32'(bus.sample_ready), 32'd0);
        checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "PktCount"}, 32'(pktCount), 32'd0);
    endtask

    initial begin
        bit found;
        bus.sample_in      = 16'h0000;
        bus.sample_valid   = 1'b0;
        bus.tx_buffer_full = 1'b0;

        #7 reset = 1'b1;
        #1 checkAllZero("reset");
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        countBusy(10, "idleNoValid");

        enable           = 1'b0;
        bus.sample_in    = 16'h5555;
        bus.sample_valid = 1'b1;
        countBusy(20, "enableLowNoStart");
        bus.sample_valid = 1'b0;
        enable           = 1'b1;
        @(negedge clk);

        applyStimulus(16'h1234, 16'hABCD, 8'h42, 0);
        waitIdle();
        checkOutput("pktCountBasic", 32'(pktCount), 32'd1);

        applyStimulus(16'h1234, 16'hABCD, 8'h42, 1);
        waitIdle();
        checkOutput("pktCountStall", 32'(pktCount), 32'd2);

        applyStimulus(16'hDEAD, 16'hBEEF, 8'h20, 2);
        waitIdle();
        checkOutput("pktCountStarve", 32'(pktCount), 32'd3);

        applyStimulus(16'h0001, 16'h8000, 8'h83, 3);
        waitIdle();
        countBusy(30, "enableDropNoRestart");
        checkOutput("pktCountEnDrop", 32'(pktCount), 32'd4);
        bus.sample_valid = 1'b0;
        enable           = 1'b1;
        @(negedge clk);

        applyStimulus(16'h1234, 16'hABCD, 8'h42, 0);
        applyStimulus(16'hDEAD, 16'hBEEF, 8'h20, 0);
        waitIdle();
        checkOutput("pktCountB2B", 32'(pktCount), 32'd6);

        expQ.push_back(8'hA5);
        expQ.push_back(8'h02);
        bus.sample_in    = 16'h1111;
        bus.sample_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            #2;
            if (expQ.size() == 0) found = 1;
        end
        if (!found) timeoutFail("reachLenWrite");
        reset = 1'b1;
        #1 checkAllZero("midReset");
        @(negedge clk);
        reset            = 1'b0;
        bus.sample_valid = 1'b0;
        repeat (2) @(negedge clk);

        applyStimulus(16'h0001, 16'h8000, 8'h83, 0);
        waitIdle();
        checkOutput("pktCountAfterReset", 32'(pktCount), 32'd1);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_sample_packetizer.md
# uart_sample_packetizer

Frames 16-bit audio samples into byte packets for the RS-232 UART transmit path. Sits between the sample playback/readout logic and `rs232_uart`, driving its `tx_data_in`/`write_tx_data` inputs and obeying its `tx_buffer_full` flag. Each packet is a header, a length byte, the big-endian sample bytes and an XOR checksum, so the host can resynchronise and validate the stream.

## Interface
- `PKT_SAMPLES`, 32: samples per packet. Legal range is 1..255; the value is sent as the LEN byte.
- `HEADER`, 8'hA5: first byte of every packet.
- `clk`  in  1: system clock, 100 MHz.
- `reset`  in  1: asynchronous, active-high. Clock is `clk`.
- `enable`  in  1: permits a new packet to start. It is sampled only in IDLE.
- `sample_in`  in  16: sample data. It is valid while `sample_valid` is high.
- `sample_valid`  in  1: upstream has a sample available.
- `sample_ready`  out  1: a sample is accepted on any cycle where `sample_valid & sample_ready`.
- `tx_data`  out  8: byte to the UART. Connects to `tx_data_in`.
- `tx_write`  out  1: single-cycle write strobe. Connects to `write_tx_data`.
- `tx_buffer_full`  in  1: UART transmit FIFO full.
- `busy`  out  1: high in every state except IDLE.
- `pkt_count`  out  16: number of packets completed. Wraps modulo 2^16.

## Operation
- States are IDLE, HDR, LEN, LOAD, MSB, LSB and CSUM.
- **IDLE:** if `enable & sample_valid`, go to HDR. The sample is not consumed in this state.
- **HDR:** emit `HEADER` and clear the checksum. Then go to LEN.
- **LEN:** emit `PKT_SAMPLES[7:0]` and set checksum = LEN. Then go to LOAD.
- **LOAD:**
  - `sample_ready` = 1.
  - On handshake: capture `sample_in` into the holding register, increment the sample counter, go to MSB.
  - Otherwise stay in LOAD indefinitely. There is no timeout.
- **MSB:** emit `hold[15:8]`, then go to LSB.
- **LSB:** emit `hold[7:0]`. If the sample counter equals `PKT_SAMPLES`, go to CSUM; otherwise go to LOAD.
- **CSUM:**
  - Emit the checksum: XOR of the LEN byte and every sample byte. HEADER is excluded.
  - Clear the sample counter, increment `pkt_count`, go to IDLE.
- **Emit rule** (applies to HDR, LEN, MSB, LSB and CSUM):
  - A byte is written only on a cycle where `tx_buffer_full == 0` and the holdoff flag is clear.
  - On the write cycle: `tx_write` = 1, `tx_data` = byte, checksum updated, state advances.
  - Otherwise the state holds with `tx_write` = 0.
- **Holdoff:** set on the cycle after any write and cleared one cycle later. This guarantees at least one idle cycle between writes, so a registered full flag is never overrun.
- **Stopping:** deasserting `enable` mid-packet has no effect; the packet completes.
- **Reset mid-packet:** the packet is dropped with no checksum, everything returns to IDLE, and the host resynchronises on HEADER.

## Timing
- Reset values:
  - state = IDLE
  - `tx_write` = 0, `tx_data` = 8'h00
  - `sample_ready` = 0, `busy` = 0
  - `pkt_count` = 0
  - sample counter = 0, checksum = 0, holdoff = 0
- All outputs are registered. `sample_ready` and `busy` are decoded from the registered state.
- `tx_data` and `tx_write` change together. `tx_data` holds its last value when `tx_write` = 0.
- With `tx_buffer_full` low and `sample_valid` constantly high, counting the IDLE detect as cycle 0:
  - HDR write at cycle 1.
  - LEN write at cycle 3.
  - First LOAD at cycle 4.
  - Each sample then takes 4 cycles: LOAD, MSB write, holdoff, LSB write.
  - CSUM write is 2 cycles after the last LSB write.
  - IDLE follows the cycle after the CSUM write.
- `tx_buffer_full` stalls only the pending write. The checksum and counters are unaffected, and the byte is written on the first cycle where full is low and holdoff is clear.
- Sample counter width is 8 bits. `pkt_count` increments on the CSUM write cycle.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle -> all outputs 0 immediately; after release, the block stays in IDLE with `busy` = 0 while `sample_valid` = 0.
- **Basic packet:** `PKT_SAMPLES`=2, samples 16'h1234 then 16'hABCD, full tied low -> byte sequence A5 02 12 34 AB CD 42, writes spaced at least 2 cycles apart, `pkt_count`=1, `busy` drops after CSUM.
- **Backpressure:** hold `tx_buffer_full`=1 for 50 cycles while in MSB -> no `tx_write` during that window; after release, the same byte 8'h12 is written exactly once and the checksum is still 42.
- **Upstream starvation:** drop `sample_valid` for 20 cycles in LOAD -> `sample_ready` stays high, no writes occur, and the packet resumes correctly when `sample_valid` returns.
- **Enable:** `enable`=0 with `sample_valid`=1 -> no packet starts; drop `enable` mid-packet -> the packet completes, no new packet starts; two back-to-back packets with `enable`=1 -> `pkt_count`=2.
- **Reset mid-packet:** reset after the LEN write, then run a fresh 2-sample packet -> output restarts at A5, and the next packet's checksum is correct and unpolluted by the aborted packet.
